controle_mul_div: RTL and testbench
===================================

// Module: controle_mul_div
// PURPOSE
//  Multi-cycle sequencer for the iterative multiplier/divider behind ALUOp 4'b1001 (mul) and 4'b1010 (div).
//  Sits beside the single-cycle ALU. Holds PC and register-file write via 'stall' while it iterates,
//  then presents the result for write-back for one cycle.
//  Runs a shift-add multiply or restoring signed divide. One operation in flight at a time.
// PARAMETERS
//  WIDTH  32  operand/result width in bits; counter width is $clog2(WIDTH)+1
// PORTS
//  clk       in   1      single clock, rising edge
//  rst_n     in   1      asynchronous, active-low reset
//  valid     in   1      current instruction is a decoded R-type (opcode 51)
//  ALUOp     in   4      from control unit; 4'b1001=mul, 4'b1010=div, others ignored
//  abort     in   1      discard in-flight operation (flush)
//  op_a      in   WIDTH  rs1 value
//  op_b      in   WIDTH  rs2 value
//  stall     out  1      hold PC, suppress regWrite
//  busy      out  1      FSM in MUL or DIV
//  done      out  1      one-cycle pulse: result valid, write back now
//  result    out  WIDTH  mul: low WIDTH bits of product; div: signed quotient
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   state=IDLE; result=0; done=0; busy=0; count=0; stall forced 0 while rst_n=0.
//  start = valid && state==IDLE && (ALUOp==4'b1001 || ALUOp==4'b1010) && !abort.
//  FSM states: IDLE, MUL, DIV, DONE.
//   IDLE -> MUL    on start with mul.
//   IDLE -> DIV    on start with div and op_b!=0.
//   IDLE -> DONE   on start with div and op_b==0.
//   MUL/DIV -> DONE   after WIDTH iterations (count==WIDTH-1).
//   MUL/DIV -> IDLE   on abort; no done, result unchanged.
//   DONE -> IDLE   always, including when abort is set.
//  On start, latch operands and clear count.
//   mul: multiplicand=op_a, multiplier=op_b.
//   div: latch |op_a|, |op_b| as unsigned, plus sign_q = op_a[MSB]^op_b[MSB].
//  Datapath, one iteration per cycle in MUL/DIV:
//   MUL: if multiplier[0], acc += multiplicand; multiplicand <<= 1; multiplier >>= 1.
//        Keep only the low WIDTH bits, so signed and unsigned give the same result.
//   DIV: restoring division on {rem, dividend} shifted left by 1.
//        If rem >= divisor: subtract divisor and set quotient bit = 1.
//        Quotient truncates toward zero; apply negation when sign_q=1 on entry to DONE.
//   div by zero: result = {WIDTH{1'b1}}.
//   overflow (most-negative / -1): result = most-negative. This falls out of unsigned magnitude math.
//  Timing, with cycle 0 = start cycle:
//   stall = start (combinational) || state==MUL || state==DIV.
//   Cycles 1..WIDTH: MUL/DIV. Cycle WIDTH+1: DONE, done=1, stall=0, result valid.
//   The instruction retires in the DONE cycle; PC advances at the end of that cycle.
//   For WIDTH=32, stall is high for 33 cycles.
//   div by zero: DONE in cycle 1; stall is high in cycle 0 only.
//  result is registered and held until written by the next completed operation.
//  done is registered and high exactly during DONE.
//  No new start is accepted in DONE; the next instruction is evaluated in IDLE on the following cycle.
//  busy = (state==MUL || state==DIV).
//  abort in cycle 0 blocks start and keeps stall=0.
//  Non-mul/div ALUOp values with valid=1 in IDLE: no effect, stall=0.
//  Reset mid-operation: returns immediately to reset values; no done pulse follows.
// TESTING
//  1. mul 7*6: ALUOp=1001, op_a=7, op_b=6 -> stall for 33 cycles, done in cycle 33, result=32'd42.
//  2. mul -3*5: op_a=32'hFFFFFFFD, op_b=5 -> result=32'hFFFFFFF1.
//  3. div -100/7: op_a=32'hFFFFFF9C, op_b=7 -> result=32'hFFFFFFF2 (-14).
//     Also 100/7 -> 32'd14.
//  4. div by zero: op_a=5, op_b=0 -> done in cycle 1, result=32'hFFFFFFFF, stall high in cycle 0 only.
//  5. overflow: op_a=32'h80000000, op_b=32'hFFFFFFFF -> result=32'h80000000, latency 33.
//  6. abort in cycle 10 of a mul -> IDLE next cycle, no done, result keeps its previous value.
//     rst_n low in cycle 5 of a div -> all outputs 0 immediately.

Source files
------------

// File: rtl/controle_mul_div.sv
// controle_mul_div: multi-cycle sequencer for the iterative multiplier / divider.
// Holds the pipeline with 'stall' while a shift-add multiply or a restoring
// signed divide iterates, then presents the result for one cycle with 'done'.
module controle_mul_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic [3:0]       ALUOp,
    input  logic             abort,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE       = CW'(1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t state, next_state;

    logic [CW-1:0]    count;
    logic             sign_q;
    // reg_a: multiplicand (MUL) or dividend shifting into quotient (DIV)
    // reg_b: multiplier (MUL) or divisor magnitude (DIV)
    // acc:   product accumulator (MUL) or partial remainder (DIV)
    logic [WIDTH-1:0] reg_a;
    logic [WIDTH-1:0] reg_b;
    logic [WIDTH-1:0] acc;

    logic             is_mul;
    logic             is_div;
    logic             start;
    logic             last_iter;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH-1:0] mul_acc_next;
    logic [WIDTH:0]   rem_shift;
    logic             rem_fits;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quot_next;
    logic [WIDTH-1:0] quot_signed;

    // Decode the request and build one iteration's worth of datapath values
    always_comb begin
        is_mul       = (ALUOp == 4'b1001);
        is_div       = (ALUOp == 4'b1010);
        start        = valid && (state == IDLE) && (is_mul || is_div) && !abort;
        last_iter    = (count == LAST_ITER);
        abs_a        = op_a[WIDTH-1] ? -op_a : op_a;
        abs_b        = op_b[WIDTH-1] ? -op_b : op_b;
        mul_acc_next = acc + (reg_b[0] ? reg_a : '0);
        rem_shift    = {acc, reg_a[WIDTH-1]};
        rem_fits     = (rem_shift >= {1'b0, reg_b});
        rem_next     = rem_fits ? (rem_shift[WIDTH-1:0] - reg_b) : rem_shift[WIDTH-1:0];
        quot_next    = {reg_a[WIDTH-2:0], rem_fits};
        quot_signed  = sign_q ? -quot_next : quot_next;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; abort wins over completion of the last iteration
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (is_mul) begin
                        next_state = MUL;
                    end else if (op_b == '0) begin
                        next_state = DONE;
                    end else begin
                        next_state = DIV;
                    end
                end
            end
            MUL, DIV: begin
                if (abort) begin
                    next_state = IDLE;
                end else if (last_iter) begin
                    next_state = DONE;
                end
            end
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs; stall is masked while reset is asserted
    always_comb begin
        busy  = (state == MUL) || (state == DIV);
        done  = (state == DONE);
        stall = rst_n && (start || busy);
    end

    // Operand latching, per-cycle iteration and result capture on entry to DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            sign_q <= 1'b0;
            reg_a  <= '0;
            reg_b  <= '0;
            acc    <= '0;
            result <= '0;
        end else if (start) begin
            count  <= '0;
            acc    <= '0;
            sign_q <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
            reg_a  <= is_mul ? op_a : abs_a;
            reg_b  <= is_mul ? op_b : abs_b;
            if (is_div && (op_b == '0)) begin
                result <= '1;
            end
        end else begin
            case (state)
                MUL: begin
                    acc   <= mul_acc_next;
                    reg_a <= reg_a << 1;
                    reg_b <= reg_b >> 1;
                    count <= count + ONE;
                    if (!abort && last_iter) begin
                        result <= mul_acc_next;
                    end
                end
                DIV: begin
                    acc   <= rem_next;
                    reg_a <= quot_next;
                    count <= count + ONE;
                    if (!abort && last_iter) begin
                        result <= quot_signed;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_controle_mul_div.sv
// tb_controle_mul_div: randomized and directed checks of the mul/div sequencer
// against an arithmetic reference model.
module tb_controle_mul_div;

    localparam int WIDTH = 32;
    localparam logic [3:0] OP_MUL = 4'b1001;
    localparam logic [3:0] OP_DIV = 4'b1010;

    logic             clk;
    logic             rst_n;
    logic             valid;
    logic [3:0]       ALUOp;
    logic             abort;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    int n_checks;
    int n_fail;
    logic [WIDTH-1:0] last_result;

    controle_mul_div #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid  (valid),
        .ALUOp  (ALUOp),
        .abort  (abort),
        .op_a   (op_a),
        .op_b   (op_b),
        .stall  (stall),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: product low bits, or signed quotient truncated toward zero
    function automatic logic [WIDTH-1:0] model(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        longint unsigned pu;
        longint sa;
        longint sb;
        longint q;
        if (op == OP_MUL) begin
            pu = longint'(a) * longint'(b);
            return pu[WIDTH-1:0];
        end
        if (b == '0) return '1;
        sa = $signed(a);
        sb = $signed(b);
        q  = sa / sb;
        return q[WIDTH-1:0];
    endfunction

    // Issue one operation and follow it to completion, checking latency, stall length and result
    task automatic run_op(input string name, input logic [3:0] op, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] exp_res;
        int exp_lat;
        int stall_cnt;
        int done_cyc;
        logic [WIDTH-1:0] got_res;
        exp_res  = model(op, a, b);
        exp_lat  = (op == OP_DIV && b == '0) ? 1 : WIDTH + 1;
        @(negedge clk);
        valid = 1'b1; ALUOp = op; op_a = a; op_b = b; abort = 1'b0;
        #1;
        n_checks++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL %s stall_cycle0 got %b expected 1", name, stall);
        end
        @(posedge clk);
        #1;
        valid = 1'b0; ALUOp = 4'b0000; op_a = $urandom; op_b = $urandom;
        stall_cnt = 1;
        done_cyc  = -1;
        got_res   = '0;
        for (int cyc = 1; cyc <= 60 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            if (stall === 1'b1) stall_cnt++;
            if (done === 1'b1) begin
                done_cyc = cyc;
                got_res  = result;
            end
        end
        n_checks++;
        if (done_cyc != exp_lat) begin
            n_fail++;
            $display("[TB] FAIL %s done_cycle got %0d expected %0d", name, done_cyc, exp_lat);
        end
        n_checks++;
        if (stall_cnt != exp_lat) begin
            n_fail++;
            $display("[TB] FAIL %s stall_cycles got %0d expected %0d", name, stall_cnt, exp_lat);
        end
        n_checks++;
        if (got_res !== exp_res) begin
            n_fail++;
            $display("[TB] FAIL %s result got %h expected %h", name, got_res, exp_res);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || result !== exp_res) begin
            n_fail++;
            $display("[TB] FAIL %s after_done done=%b busy=%b result=%h expected 0 0 %h",
                     name, done, busy, result, exp_res);
        end
        last_result = exp_res;
    endtask

    // Reset values, including stall masked while a start is requested under reset
    task automatic test_reset();
        rst_n = 1'b0; valid = 1'b1; ALUOp = OP_MUL; abort = 1'b0; op_a = 7; op_b = 6;
        repeat (2) @(negedge clk);
        n_checks++;
        if (stall !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_values stall=%b busy=%b done=%b result=%h expected all 0",
                     stall, busy, done, result);
        end
        valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        last_result = '0;
    endtask

    // Directed vectors from the worked examples
    task automatic test_directed();
        run_op("mul_7x6",    OP_MUL, 32'd7,          32'd6);
        run_op("mul_m3x5",   OP_MUL, 32'hFFFFFFFD,   32'd5);
        run_op("div_m100_7", OP_DIV, 32'hFFFFFF9C,   32'd7);
        run_op("div_100_7",  OP_DIV, 32'd100,        32'd7);
        run_op("div_zero",   OP_DIV, 32'd5,          32'd0);
        run_op("div_ovf",    OP_DIV, 32'h80000000,   32'hFFFFFFFF);
        run_op("div_100_m7", OP_DIV, 32'd100,        32'hFFFFFFF9);
    endtask

    // Random mul/div operations, with occasional zero divisors and small operands
    task automatic test_random();
        logic [3:0] op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        for (int i = 0; i < 10; i++) begin
            op = ($urandom_range(0, 1) == 0) ? OP_MUL : OP_DIV;
            a  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 1000)) : $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'd0 :
                 (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 50)) : $urandom);
            run_op("random", op, a, b);
        end
    endtask

    // Abort and non-mul/div opcodes in the start cycle must not start anything
    task automatic test_no_start();
        logic [3:0] other;
        @(negedge clk);
        valid = 1'b1; ALUOp = OP_MUL; abort = 1'b1; op_a = 3; op_b = 4;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL abort_cycle0 stall got %b expected 0", stall);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || stall !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL abort_cycle0_after busy=%b stall=%b expected 0 0", busy, stall);
        end
        abort = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do other = 4'($urandom_range(0, 15)); while (other == OP_MUL || other == OP_DIV);
            ALUOp = other; valid = 1'b1;
            #1;
            n_checks++;
            if (stall !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL other_op stall got %b expected 0 (ALUOp=%b)", stall, other);
            end
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL other_op_after busy=%b done=%b expected 0 0", busy, done);
            end
        end
        valid = 1'b0; ALUOp = 4'b0000;
    endtask

    // Abort in cycle 10 of a multiply: back to idle, no done, result preserved
    task automatic test_abort();
        int done_seen;
        @(negedge clk);
        valid = 1'b1; ALUOp = OP_MUL; op_a = $urandom; op_b = $urandom; abort = 1'b0;
        @(posedge clk);
        #1;
        valid = 1'b0;
        repeat (10) @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || stall !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL abort_idle busy=%b stall=%b expected 0 0", busy, stall);
        end
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        n_checks++;
        if (done_seen != 0 || result !== last_result) begin
            n_fail++;
            $display("[TB] FAIL abort_no_done done_pulses=%0d result=%h expected 0 %h",
                     done_seen, result, last_result);
        end
    endtask

    // Reset in cycle 5 of a divide: outputs clear immediately and no done follows
    task automatic test_reset_mid();
        int done_seen;
        @(negedge clk);
        valid = 1'b1; ALUOp = OP_DIV; op_a = 32'd1000; op_b = 32'd3; abort = 1'b0;
        @(posedge clk);
        #1;
        valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (stall !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_mid stall=%b busy=%b done=%b result=%h expected all 0",
                     stall, busy, done, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        n_checks++;
        if (done_seen != 0) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_no_done active_cycles got %0d expected 0", done_seen);
        end
        last_result = '0;
    endtask

    // valid held high across DONE: no start in DONE, the next one starts in the following idle cycle
    task automatic test_back_to_back();
        int done_cyc;
        logic [WIDTH-1:0] exp_res;
        exp_res = model(OP_MUL, 32'd123, 32'd456);
        @(negedge clk);
        valid = 1'b1; ALUOp = OP_MUL; op_a = 32'd123; op_b = 32'd456; abort = 1'b0;
        done_cyc = -1;
        for (int cyc = 1; cyc <= 60 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            if (done === 1'b1) done_cyc = cyc;
        end
        n_checks++;
        if (done_cyc != WIDTH + 1 || stall !== 1'b0 || result !== exp_res) begin
            n_fail++;
            $display("[TB] FAIL b2b_first done_cycle=%0d stall=%b result=%h expected %0d 0 %h",
                     done_cyc, stall, result, WIDTH + 1, exp_res);
        end
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL b2b_restart stall=%b done=%b expected 1 0", stall, done);
        end
        @(posedge clk);
        #1;
        valid = 1'b0;
        done_cyc = -1;
        for (int cyc = 1; cyc <= 60 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            if (done === 1'b1) done_cyc = cyc;
        end
        n_checks++;
        if (done_cyc != WIDTH + 1 || result !== exp_res) begin
            n_fail++;
            $display("[TB] FAIL b2b_second done_cycle=%0d result=%h expected %0d %h",
                     done_cyc, result, WIDTH + 1, exp_res);
        end
        last_result = exp_res;
        @(negedge clk);
    endtask

    // Run all scenarios in sequence
    initial begin
        n_checks = 0;
        n_fail   = 0;
        valid = 1'b0; ALUOp = 4'b0000; abort = 1'b0; op_a = '0; op_b = '0; rst_n = 1'b0;
        last_result = '0;
        test_reset();
        test_directed();
        test_random();
        test_no_start();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
